// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - operand-bypass select bus between ID decode and fwd_hazard_ctrl
interface fwd_hazard_ctrl_if #(
  parameter int NREG_W = 5,
  parameter int LAT_W  = 2
);
  logic              pipe_hold;
  logic              flush;
  logic              id_valid;
  logic [NREG_W-1:0] id_rs;
  logic [NREG_W-1:0] id_rt;
  logic              id_rs_use;
  logic              id_rt_use;
  logic              id_rs_early;
  logic              id_rt_early;
  logic              id_wr_en;
  logic [NREG_W-1:0] id_wr_addr;
  logic [LAT_W-1:0]  id_wr_lat;
  logic              stall_id;
  logic [1:0]        id_rs_sel;
  logic [1:0]        id_rt_sel;
  logic [1:0]        ex_rs_sel;
  logic [1:0]        ex_rt_sel;
  logic [31:0]       stall_cnt;

  modport master (
    output pipe_hold, flush, id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
           id_rs_early, id_rt_early, id_wr_en, id_wr_addr, id_wr_lat,
    input  stall_id, id_rs_sel, id_rt_sel, ex_rs_sel, ex_rt_sel, stall_cnt
  );

  modport slave (
    input  pipe_hold, flush, id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
           id_rs_early, id_rt_early, id_wr_en, id_wr_addr, id_wr_lat,
    output stall_id, id_rs_sel, id_rt_sel, ex_rs_sel, ex_rt_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - bypass select and load-use stall control; FWD_STALL_CNT_EN adds a stall cycle counter
module fwd_hazard_ctrl #(
  parameter int NREG_W = 5,
  parameter int LAT_W  = 2
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam int NST = 4;
  localparam logic [1:0] ST_EX = 2'd0;
  localparam logic [1:0] ST_M1 = 2'd1;
  localparam logic [1:0] ST_M2 = 2'd2;
  localparam logic [1:0] ST_WB = 2'd3;

  localparam logic [1:0] ID_GPR = 2'b00;
  localparam logic [1:0] ID_WD  = 2'b01;
  localparam logic [1:0] ID_EM1 = 2'b10;
  localparam logic [1:0] ID_M12 = 2'b11;

  localparam logic [1:0] EX_OPD = 2'b00;
  localparam logic [1:0] EX_EM1 = 2'b01;
  localparam logic [1:0] EX_M12 = 2'b10;
  localparam logic [1:0] EX_M2W = 2'b11;

  // Shadow scoreboard, index 0 = EX (youngest) .. 3 = WB (oldest)
  logic              st_v [NST];
  logic [NREG_W-1:0] st_d [NST];
  logic [LAT_W-1:0]  st_l [NST];

  logic [NREG_W-1:0] op_idx   [2];
  logic              op_use   [2];
  logic              op_early [2];

  logic              op_hit   [2];
  logic [1:0]        op_stage [2];
  logic [LAT_W-1:0]  op_lat   [2];
  logic              op_nr    [2];
  logic [1:0]        id_sel   [2];
  logic [1:0]        ex_sel_nx[2];

  logic              stall_id;
  logic              id_take;
  logic [1:0]        ex_rs_q;
  logic [1:0]        ex_rt_q;

  assign op_idx[0]   = bus.id_rs;
  assign op_idx[1]   = bus.id_rt;
  assign op_use[0]   = bus.id_rs_use;
  assign op_use[1]   = bus.id_rt_use;
  assign op_early[0] = bus.id_rs_early;
  assign op_early[1] = bus.id_rt_early;

  // Scanning oldest to youngest lets the youngest match overwrite older ones
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      op_hit[k]    = 1'b0;
      op_stage[k]  = ST_EX;
      op_lat[k]    = '0;
      op_nr[k]     = 1'b0;
      id_sel[k]    = ID_GPR;
      ex_sel_nx[k] = EX_OPD;
      if (op_use[k] && (op_idx[k] != '0)) begin
        for (int s = NST - 1; s >= 0; s--) begin
          if (st_v[s] && (st_d[s] == op_idx[k])) begin
            op_hit[k]   = 1'b1;
            op_stage[k] = 2'(s);
            op_lat[k]   = st_l[s];
          end
        end
      end
      if (op_hit[k]) begin
        if (op_early[k]) begin
          case (op_stage[k])
            ST_EX: op_nr[k] = 1'b1;
            ST_M1: begin
              op_nr[k]  = (op_lat[k] != '0);
              id_sel[k] = ID_EM1;
            end
            ST_M2: begin
              op_nr[k]  = (op_lat[k] > LAT_W'(1));
              id_sel[k] = ID_M12;
            end
            ST_WB: id_sel[k] = ID_WD;
            default: id_sel[k] = ID_GPR;
          endcase
        end else begin
          // Selects are chosen for the cycle the consumer will spend in EX
          case (op_stage[k])
            ST_EX: begin
              op_nr[k]     = (op_lat[k] != '0);
              ex_sel_nx[k] = EX_EM1;
            end
            ST_M1: begin
              op_nr[k]     = (op_lat[k] > LAT_W'(1));
              ex_sel_nx[k] = EX_M12;
            end
            ST_M2: ex_sel_nx[k] = EX_M2W;
            ST_WB: ex_sel_nx[k] = EX_OPD;
            default: ex_sel_nx[k] = EX_OPD;
          endcase
        end
      end
      if (op_nr[k]) begin
        id_sel[k] = ID_GPR;
      end
    end
  end

  assign stall_id = bus.id_valid && (op_nr[0] || op_nr[1]);
  assign id_take  = bus.id_valid && !stall_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NST; s++) begin
        st_v[s] <= 1'b0;
        st_d[s] <= '0;
        st_l[s] <= '0;
      end
      ex_rs_q <= EX_OPD;
      ex_rt_q <= EX_OPD;
    end else if (bus.flush) begin
      // The killed MEM1 entry must not reach MEM2; the surviving MEM2 retires
      st_v[ST_WB] <= st_v[ST_M2];
      st_d[ST_WB] <= st_d[ST_M2];
      st_l[ST_WB] <= st_l[ST_M2];
      st_v[ST_M2] <= 1'b0;
      st_v[ST_M1] <= 1'b0;
      st_v[ST_EX] <= 1'b0;
      ex_rs_q     <= EX_OPD;
      ex_rt_q     <= EX_OPD;
    end else if (!bus.pipe_hold) begin
      for (int s = NST - 1; s > 0; s--) begin
        st_v[s] <= st_v[s-1];
        st_d[s] <= st_d[s-1];
        st_l[s] <= st_l[s-1];
      end
      st_v[ST_EX] <= id_take && bus.id_wr_en && (bus.id_wr_addr != '0);
      st_d[ST_EX] <= bus.id_wr_addr;
      st_l[ST_EX] <= bus.id_wr_lat;
      ex_rs_q     <= id_take ? ex_sel_nx[0] : EX_OPD;
      ex_rt_q     <= id_take ? ex_sel_nx[1] : EX_OPD;
    end
  end

  assign bus.stall_id  = stall_id;
  assign bus.id_rs_sel = id_sel[0];
  assign bus.id_rt_sel = id_sel[1];
  assign bus.ex_rs_sel = ex_rs_q;
  assign bus.ex_rt_sel = ex_rt_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_id && !bus.pipe_hold) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed-vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

`ifdef FWD_STALL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic rse, input logic rte,
                       input logic we, input logic [4:0] wa, input logic [1:0] lat);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rs_use   = rsu;
    bus.id_rt_use   = rtu;
    bus.id_rs_early = rse;
    bus.id_rt_early = rte;
    bus.id_wr_en    = we;
    bus.id_wr_addr  = wa;
    bus.id_wr_lat   = lat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.pipe_hold = 1'b0;
    bus.flush     = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.pipe_hold = 1'b0;
    bus.flush     = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd2);
    step();
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b00) begin n_bad++; $display("FAIL reset_ex_rs: got %b want 00", bus.ex_rs_sel); end
    n_cmp++; if (bus.ex_rt_sel !== 2'b00) begin n_bad++; $display("FAIL reset_ex_rt: got %b want 00", bus.ex_rt_sel); end
    n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt); end
    step();
    rst_n = 1'b1;
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL reset_no_stall: got %b want 0", bus.stall_id); end
    n_cmp++; if (bus.id_rs_sel !== 2'b00) begin n_bad++; $display("FAIL reset_id_rs: got %b want 00", bus.id_rs_sel); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd2);
    step();
    idle();
    step();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", bus.stall_id); end
    n_cmp++; if (bus.id_rs_sel !== 2'b00) begin n_bad++; $display("FAIL lu_id_rs: got %b want 00", bus.id_rs_sel); end
    step();
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %b want 0", bus.stall_id); end
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b11) begin n_bad++; $display("FAIL lu_ex_rs: got %b want 11", bus.ex_rs_sel); end
    n_cmp++; if (bus.ex_rt_sel !== 2'b00) begin n_bad++; $display("FAIL lu_ex_rt: got %b want 00", bus.ex_rt_sel); end
    n_cmp++; if (bus.stall_cnt !== 32'(CNT_ON)) begin n_bad++; $display("FAIL lu_cnt: got %0d want %0d", bus.stall_cnt, CNT_ON); end
    step();
  endtask

  task automatic test_branch_early();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0);
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b1) begin n_bad++; $display("FAIL br_stall: got %b want 1", bus.stall_id); end
    n_cmp++; if (bus.id_rs_sel !== 2'b00) begin n_bad++; $display("FAIL br_id_rs_stalled: got %b want 00", bus.id_rs_sel); end
    step();
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL br_release: got %b want 0", bus.stall_id); end
    n_cmp++; if (bus.id_rs_sel !== 2'b10) begin n_bad++; $display("FAIL br_id_rs: got %b want 10", bus.id_rs_sel); end
    n_cmp++; if (bus.id_rt_sel !== 2'b00) begin n_bad++; $display("FAIL br_id_rt: got %b want 00", bus.id_rt_sel); end
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b00) begin n_bad++; $display("FAIL br_ex_rs: got %b want 00", bus.ex_rs_sel); end
    step();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 2'd0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", bus.stall_id); end
    n_cmp++; if (bus.id_rs_sel !== 2'b00) begin n_bad++; $display("FAIL zero_id_rs: got %b want 00", bus.id_rs_sel); end
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rt_sel !== 2'b00) begin n_bad++; $display("FAIL zero_ex_rt: got %b want 00", bus.ex_rt_sel); end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd0);
    step();
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", bus.stall_id); end
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b01) begin n_bad++; $display("FAIL b2b_ex_rs: got %b want 01", bus.ex_rs_sel); end
    n_cmp++; if (bus.ex_rt_sel !== 2'b01) begin n_bad++; $display("FAIL b2b_ex_rt: got %b want 01", bus.ex_rt_sel); end
    step();
  endtask

  task automatic test_early_wb();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 2'd2);
    step();
    idle();
    step();
    step();
    drive(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b1) begin n_bad++; $display("FAIL ewb_m2_stall: got %b want 1", bus.stall_id); end
    step();
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL ewb_release: got %b want 0", bus.stall_id); end
    n_cmp++; if (bus.id_rs_sel !== 2'b01) begin n_bad++; $display("FAIL ewb_id_rs: got %b want 01", bus.id_rs_sel); end
    step();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd2);
    step();
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL fl_stall: got %b want 0", bus.stall_id); end
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b00) begin n_bad++; $display("FAIL fl_ex_rs: got %b want 00", bus.ex_rs_sel); end
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 2'd0);
    step();
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b01) begin n_bad++; $display("FAIL fl_pre_ex_rs: got %b want 01", bus.ex_rs_sel); end
    bus.flush     = 1'b1;
    bus.pipe_hold = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.pipe_hold = 1'b0;
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b00) begin n_bad++; $display("FAIL fl_over_hold: got %b want 00", bus.ex_rs_sel); end
    step();
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 2'd1);
    step();
    idle();
    step();
    bus.pipe_hold = 1'b1;
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL hold_stall[%0d]: got %b want 0", i, bus.stall_id); end
      n_cmp++; if (bus.ex_rs_sel !== 2'b00) begin n_bad++; $display("FAIL hold_ex_rs[%0d]: got %b want 00", i, bus.ex_rs_sel); end
      step();
    end
    bus.pipe_hold = 1'b0;
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b10) begin n_bad++; $display("FAIL hold_ex_rs_after: got %b want 10", bus.ex_rs_sel); end
    n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL hold_cnt0: got %0d want 0", bus.stall_cnt); end

    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 2'd1);
    step();
    bus.pipe_hold = 1'b1;
    drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (bus.stall_id !== 1'b1) begin n_bad++; $display("FAIL hold_mul_stall[%0d]: got %b want 1", i, bus.stall_id); end
      step();
    end
    settle();
    n_cmp++; if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL hold_cnt_frozen: got %0d want 0", bus.stall_cnt); end
    bus.pipe_hold = 1'b0;
    n_cmp++; if (bus.stall_id !== 1'b1) begin n_bad++; $display("FAIL hold_mul_live: got %b want 1", bus.stall_id); end
    step();
    settle();
    n_cmp++; if (bus.stall_id !== 1'b0) begin n_bad++; $display("FAIL hold_mul_release: got %b want 0", bus.stall_id); end
    n_cmp++; if (bus.stall_cnt !== 32'(CNT_ON)) begin n_bad++; $display("FAIL hold_cnt1: got %0d want %0d", bus.stall_cnt, CNT_ON); end
    step();
    idle();
    settle();
    n_cmp++; if (bus.ex_rs_sel !== 2'b10) begin n_bad++; $display("FAIL hold_mul_ex_rs: got %b want 10", bus.ex_rs_sel); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_use();
    test_branch_early();
    test_zero_reg();
    test_back_to_back();
    test_early_wb();
    test_flush();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
